// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
//   muldiv_op_e    : RV32M funct3 encoding of the operation
//   muldiv_state_e : control FSM states
//   ITER           : iterations per non-special operation (one bit each)
package muldiv_pkg;

    localparam int unsigned ITER = 32;

    typedef enum logic [2:0] {
        OpMul    = 3'd0,
        OpMulh   = 3'd1,
        OpMulhsu = 3'd2,
        OpMulhu  = 3'd3,
        OpDiv    = 3'd4,
        OpDivu   = 3'd5,
        OpRem    = 3'd6,
        OpRemu   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } muldiv_state_e;

    function automatic logic op_is_div(muldiv_op_e op);
        return op inside {OpDiv, OpDivu, OpRem, OpRemu};
    endfunction

    function automatic logic op_a_signed(muldiv_op_e op);
        return op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
    endfunction

    function automatic logic op_b_signed(muldiv_op_e op);
        return op inside {OpMul, OpMulh, OpDiv, OpRem};
    endfunction

endpackage

// File: rtl/muldiv_abs_neg.sv
// Conditional two's-complement negate (purely combinational).
//   val_i : input value
//   neg_i : 1 -> res_o = -val_i, 0 -> res_o = val_i
//   res_o : result, modulo 2^W
module muldiv_abs_neg #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    always_comb begin
        res_o = neg_i ? (~val_i + W'(1)) : val_i;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Radix-2: one multiplier bit or one
// quotient bit per BUSY cycle (32 cycles), single-cycle fast path for divide
// by zero and signed divide overflow. Result is a registered one-cycle
// writeback pulse that drives the register-file write port.
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   start_i       : request, sampled only while idle
//   op_i          : RV32M funct3
//   rs1_data_i    : operand A (dividend / multiplicand)
//   rs2_data_i    : operand B (divisor / multiplier)
//   rd_i          : destination register index
//   flush_i       : kill any in-flight operation
//   busy_o        : high while an operation is in BUSY or DONE
//   done_o        : one-cycle result-valid pulse
//   wb_en_o       : done_o and captured rd != 0
//   wb_rd_o       : captured rd, held until the next done
//   wb_data_o     : result, held until the next done
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            wb_en_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o
);

    localparam int unsigned CntW = $clog2(ITER);
    localparam logic [CntW-1:0] LastCnt = CntW'(ITER - 1);

    muldiv_state_e     state_q, state_d;
    muldiv_op_e        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_q, acc_d;       // {hi: product / remainder, lo: multiplier / quotient}
    logic [CntW-1:0]   count_q, count_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;

    // ---------------------------------------------------------------------
    // Capture-time decode
    // ---------------------------------------------------------------------
    muldiv_op_e      op_in;
    logic            in_sign_a, in_sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            accept;
    logic            div_by_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    assign op_in     = muldiv_op_e'(op_i);
    assign in_sign_a = op_a_signed(op_in) & rs1_data_i[XLEN-1];
    assign in_sign_b = op_b_signed(op_in) & rs2_data_i[XLEN-1];
    assign accept    = (state_q == StIdle) && start_i && !flush_i;

    muldiv_abs_neg #(.W(XLEN)) u_abs_a (
        .val_i (rs1_data_i),
        .neg_i (in_sign_a),
        .res_o (mag_a)
    );

    muldiv_abs_neg #(.W(XLEN)) u_abs_b (
        .val_i (rs2_data_i),
        .neg_i (in_sign_b),
        .res_o (mag_b)
    );

    assign div_by_zero = op_is_div(op_in) && (rs2_data_i == '0);
    assign div_ovf     = (op_in inside {OpDiv, OpRem})
                         && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}})
                         && (rs2_data_i == '1);
    assign special     = div_by_zero || div_ovf;

    always_comb begin
        special_res = '0;
        if (div_by_zero) begin
            special_res = (op_in inside {OpDiv, OpDivu}) ? '1 : rs1_data_i;
        end else if (op_in == OpDiv) begin
            // Overflow quotient equals the dividend (most negative value).
            special_res = rs1_data_i;
        end
    end

    // ---------------------------------------------------------------------
    // One iteration step of the shared datapath
    // ---------------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;  // 33-bit partial remainder
    logic              div_ge;
    logic [XLEN-1:0]   div_sub;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] step_next;

    // Shift-add: add the multiplicand into the top half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc_q[0]}} & opnd_q};
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring division: shift in the next dividend bit; the remainder stays
    // below the divisor, so the difference always fits in XLEN bits.
    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_sub   = div_shift[XLEN-1:0] - opnd_q;
    assign div_next  = div_ge ? {div_sub, acc_q[XLEN-2:0], 1'b1}
                              : {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

    assign step_next = op_is_div(op_q) ? div_next : mul_next;

    // ---------------------------------------------------------------------
    // Final sign fix on the last iteration
    // ---------------------------------------------------------------------
    logic [2*XLEN-1:0] fix_in, fix_out;
    logic              fix_neg;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        fix_in  = step_next;
        fix_neg = sign_a_q ^ sign_b_q;
        if (op_q inside {OpDiv, OpDivu}) begin
            fix_in = {{XLEN{1'b0}}, step_next[XLEN-1:0]};
        end else if (op_q inside {OpRem, OpRemu}) begin
            fix_in  = {{XLEN{1'b0}}, step_next[2*XLEN-1:XLEN]};
            fix_neg = sign_a_q;
        end
    end

    muldiv_abs_neg #(.W(2*XLEN)) u_fix (
        .val_i (fix_in),
        .neg_i (fix_neg),
        .res_o (fix_out)
    );

    assign final_res = (op_q inside {OpMulh, OpMulhsu, OpMulhu}) ? fix_out[2*XLEN-1:XLEN]
                                                                 : fix_out[XLEN-1:0];

    // ---------------------------------------------------------------------
    // Control FSM: state register / next state / outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_i) state_d = special ? StDone : StBusy;
            StBusy: if (count_q == LastCnt) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush_i) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        busy_o    = state_q != StIdle;
        done_o    = state_q == StDone;
        wb_en_o   = (state_q == StDone) && (wb_rd_q != '0);
        wb_rd_o   = wb_rd_q;
        wb_data_o = wb_data_q;
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_comb begin
        op_d      = op_q;
        rd_d      = rd_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        count_d   = count_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        if (accept) begin
            op_d     = op_in;
            rd_d     = rd_i;
            sign_a_d = in_sign_a;
            sign_b_d = in_sign_b;
            count_d  = '0;
            acc_d    = {{XLEN{1'b0}}, op_is_div(op_in) ? mag_a : mag_b};
            opnd_d   = op_is_div(op_in) ? mag_b : mag_a;
            if (special) begin
                wb_rd_d   = rd_i;
                wb_data_d = special_res;
            end
        end else if (state_q == StBusy) begin
            acc_d   = step_next;
            count_d = count_q + CntW'(1);
            // Writeback registers only load when DONE is really entered.
            if (count_q == LastCnt && !flush_i) begin
                wb_rd_d   = rd_q;
                wb_data_d = final_res;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= OpMul;
            rd_q      <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            op_q      <= op_d;
            rd_q      <= rd_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        flush;
    logic        busy;
    logic        done;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .op_i       (op),
        .rs1_data_i (rs1),
        .rs2_data_i (rs2),
        .rd_i       (rd),
        .flush_i    (flush),
        .busy_o     (busy),
        .done_o     (done),
        .wb_en_o    (wb_en),
        .wb_rd_o    (wb_rd),
        .wb_data_o  (wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: RV32M semantics straight from 64-bit arithmetic
    // ------------------------------------------------------------------
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb, ub;
        logic [63:0] p;
        logic ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'd0;
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
        logic is_div, is_signed_div, ovf;
        is_div        = (o >= 3'd4);
        is_signed_div = (o == 3'd4) || (o == 3'd6);
        ovf           = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        return (is_div && (b == 0 || (is_signed_div && ovf))) ? 1 : 33;
    endfunction

    // Model state: one accepted operation (by cycle stamp) and the last
    // committed writeback.
    int          cyc = 0;
    bit          pend = 0;
    int          pend_c0 = 0;
    int          pend_done = 0;
    logic [4:0]  pend_rd = '0;
    logic [31:0] pend_data = '0;
    logic [4:0]  cm_rd = '0;
    logic [31:0] cm_data = '0;

    function automatic bit m_busy(input int k);
        return pend && (k > pend_c0) && (k <= pend_done);
    endfunction

    function automatic bit m_done(input int k);
        return pend && (k == pend_done);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            pend    = 0;
            cm_rd   = '0;
            cm_data = '0;
        end else if (flush) begin
            pend = 0;
        end else if (start && !m_busy(cyc)) begin
            pend      = 1;
            pend_c0   = cyc;
            pend_done = cyc + ref_lat(op, rs1, rs2);
            pend_rd   = rd;
            pend_data = ref_result(op, rs1, rs2);
        end
        cyc++;
    end

    // Compare process: every cycle, all outputs against the model.
    always @(negedge clk) begin
        if (m_done(cyc)) begin
            cm_rd   = pend_rd;
            cm_data = pend_data;
        end
        chk("busy", busy, m_busy(cyc));
        chk("done", done, m_done(cyc));
        chk("wb_en", wb_en, m_done(cyc) && (cm_rd != 0));
        chk("wb_rd", wb_rd, cm_rd);
        chk("wb_data", wb_data, cm_data);
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] data;
        int          lat;
        bit          seen;
        logic        en;
        logic [4:0]  rdx;
        logic        busy_post;
        logic        busy_poke;
    } res_t;

    localparam int PkNone  = 0;
    localparam int PkStart = 1;
    localparam int PkFlush = 2;
    localparam int PkRst   = 3;

    // Called at a negedge; drives start in that cycle (cycle 0) and returns
    // at the negedge of cycle `hold`.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, input int hold, input int pk, input int pk_at,
                          output res_t r);
        r.data = '0; r.lat = -1; r.seen = 0; r.en = 0; r.rdx = '0;
        r.busy_post = 1'bx; r.busy_poke = 1'bx;
        op = o; rs1 = a; rs2 = b; rd = d; start = 1'b1;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (done && !r.seen) begin
                r.seen = 1; r.lat = i; r.data = wb_data; r.en = wb_en; r.rdx = wb_rd;
            end
            if (r.seen && i == r.lat + 1) r.busy_post = busy;
            if (pk != PkNone && i == pk_at + 1) begin
                r.busy_poke = busy;
                start = 1'b0;
                flush = 1'b0;
                if (pk == PkRst) begin #2; rst = 1'b0; end
            end
            if (pk != PkNone && i == pk_at) begin
                case (pk)
                    PkStart: begin
                        start = 1'b1; op = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
                        rd = 5'($urandom);
                    end
                    PkFlush: flush = 1'b1;
                    default: begin
                        #2;
                        rst = 1'b1;
                        pend = 0; cm_rd = '0; cm_data = '0;
                        #1;
                        chk("rst_busy", busy, 0);
                        chk("rst_done", done, 0);
                        chk("rst_wb_en", wb_en, 0);
                        chk("rst_wb_rd", wb_rd, 0);
                        chk("rst_wb_data", wb_data, 0);
                    end
                endcase
            end
        end
    endtask

    task automatic expect_op(input string name, input logic [2:0] o, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        res_t r;
        run_op(o, a, b, 5'd9, 40, PkNone, 0, r);
        chk({name, "_seen"}, r.seen, 1);
        chk({name, "_data"}, r.data, exp);
        chk({name, "_lat"}, r.lat, exp_lat);
        chk({name, "_busy_after"}, r.busy_post, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        res_t        r;
        logic [2:0]  o;
        logic [31:0] a, b;
        int          lat, hold, pk, pk_at, sel;

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_wb_en", wb_en, 0);
        chk("reset_wb_rd", wb_rd, 0);
        chk("reset_wb_data", wb_data, 0);
        #2 rst = 1'b0;
        @(negedge clk);

        // Pin the model with hand-computed values.
        chk("pin_mulhsu", ref_result(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        chk("pin_rem", ref_result(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("pin_mulh_min", ref_result(3'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);

        // MUL 7 * -3, rd=5.
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 40, PkNone, 0, r);
        chk("mul_data", r.data, 32'hFFFF_FFEB);
        chk("mul_lat", r.lat, 33);
        chk("mul_wb_en", r.en, 1);
        chk("mul_wb_rd", r.rdx, 5);
        chk("mul_busy_after", r.busy_post, 0);

        expect_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        expect_op("mulh_ff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        expect_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        expect_op("mul_ff", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
        expect_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        expect_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        expect_op("divu_big", 3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33);
        expect_op("remu_big", 3'd7, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 33);
        expect_op("div_by0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        expect_op("remu_by0", 3'd7, 32'd5, 32'd0, 32'd5, 1);
        expect_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        expect_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        // rd = 0: done pulses, no write enable.
        run_op(3'd0, 32'd6, 32'd7, 5'd0, 40, PkNone, 0, r);
        chk("rd0_seen", r.seen, 1);
        chk("rd0_wb_en", r.en, 0);
        chk("rd0_data", r.data, 32'd42);

        // start during busy is ignored.
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 40, PkStart, 10, r);
        chk("ign_data", r.data, 32'hFFFF_FFEB);
        chk("ign_lat", r.lat, 33);

        // flush in cycle 10: idle in cycle 11, no done.
        run_op(3'd5, 32'd1000, 32'd7, 5'd3, 40, PkFlush, 10, r);
        chk("flush_no_done", r.seen, 0);
        chk("flush_busy_11", r.busy_poke, 0);

        // reset in cycle 20 of a DIV, then a fresh MUL.
        run_op(3'd4, 32'd1000, 32'd7, 5'd3, 40, PkRst, 20, r);
        chk("rst_no_done", r.seen, 0);
        run_op(3'd0, 32'd3, 32'd4, 5'd8, 40, PkNone, 0, r);
        chk("post_rst_data", r.data, 32'd12);
        chk("post_rst_lat", r.lat, 33);

        // Randomized ops, back-to-back where possible, with occasional pokes.
        for (int n = 0; n < 80; n++) begin
            o   = 3'($urandom);
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 5);
            if (sel == 0) begin
                b = 32'd0;
            end else if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (sel == 2) begin
                a = $urandom_range(0, 40) - 20;
                b = $urandom_range(0, 10) - 5;
            end
            lat   = ref_lat(o, a, b);
            pk    = PkNone;
            pk_at = 0;
            sel   = $urandom_range(0, 7);
            if (sel == 0) begin
                pk    = PkFlush;
                pk_at = $urandom_range(1, lat);
            end else if (sel == 1 && lat > 1) begin
                pk    = PkStart;
                pk_at = $urandom_range(2, lat);
            end
            hold = lat + 1 + $urandom_range(0, 2);
            run_op(o, a, b, 5'($urandom), hold, pk, pk_at, r);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
